// File: rtl/spi_share_pkg.sv
// Shared types and helpers for the SPI engine sharing arbiter.
package spi_share_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Index width for N requesters; at least one bit so a 2-way arbiter still has a select.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr_i (wrapping).
module rr_pick
  import spi_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  int               c;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to ptr_i so the closest one is written last.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    c        = 0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c    = (int'(ptr_i) + k) % N_REQ;
      cand = IDX_W'(c);
      if (req_i[cand]) begin
        winner_o = cand;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_share_arbiter.sv
// spi_share_arbiter: round-robin, burst-locked sharing of one SPI byte engine among N_REQ requesters.
// Optional forced release of idle owners is enabled with `define SPI_SHARE_ARBITER_TIMEOUT_EN.
module spi_share_arbiter
  import spi_share_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  DW          = DW_DEFAULT,
  parameter int  TIMEOUT_CYC = 4096,
  localparam int IDX_W       = idx_w(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_txd,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rxd,
  output logic                eng_start,
  output logic [DW-1:0]       eng_txd,
  input  logic                eng_busy,
  input  logic                eng_done,
  input  logic [DW-1:0]       eng_rxd,
  output logic [IDX_W-1:0]    eng_ss_sel,
  output logic                eng_ss_act,
  output logic [N_REQ-1:0]    timeout_err,
  output logic [1:0]          dbg_state_o
);

  // Handshake: a TX byte moves on the cycle the owner presents req_valid while the FSM is in
  // OWN and eng_busy is low; req_ready, eng_start and the registered eng_txd all appear on the
  // following cycle. Non-owner req_valid is never looked at.

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  own_q, own_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              ss_act_q, ss_act_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rxd_q, rsp_rxd_d;
  logic              eng_start_q, eng_start_d;
  logic [DW-1:0]     eng_txd_q, eng_txd_d;
  logic              drop_q, drop_d;
  logic              rel;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              own_req;
  logic [DW-1:0]     own_txd;

`ifdef SPI_SHARE_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [N_REQ-1:0]  to_err_q, to_err_d;
`else
  logic              unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  assign own_req = req[own_q];
  assign own_txd = req_txd[int'(own_q)*DW +: DW];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    gnt_d       = gnt_q;
    ss_act_d    = ss_act_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rxd_d   = rsp_rxd_q;
    eng_start_d = 1'b0;
    eng_txd_d   = eng_txd_q;
    drop_d      = drop_q;
    rel         = 1'b0;
`ifdef SPI_SHARE_ARBITER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    to_err_d    = to_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          own_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          ss_act_d        = 1'b1;
          drop_d          = 1'b0;
          state_d         = OWN;
`ifdef SPI_SHARE_ARBITER_TIMEOUT_EN
          to_cnt_d        = '0;
`endif
        end
      end

      // A drop on the same cycle as req_valid wins: no byte is taken.
      OWN: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (req_valid[own_q] && !eng_busy) begin
          req_ready_d[own_q] = 1'b1;
          eng_txd_d          = own_txd;
          eng_start_d        = 1'b1;
          drop_d             = 1'b0;
          state_d            = XFER;
`ifdef SPI_SHARE_ARBITER_TIMEOUT_EN
          to_cnt_d           = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          rel             = 1'b1;
          to_err_d[own_q] = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end

      // Remember a drop seen at any point of the transfer, even if req comes back.
      XFER: begin
        if (!own_req) begin
          drop_d = 1'b1;
        end
        if (eng_done) begin
          rsp_rxd_d          = eng_rxd;
          rsp_valid_d[own_q] = 1'b1;
          state_d            = (drop_q || !own_req) ? DRAIN : OWN;
        end
      end

      DRAIN: begin
        rel = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rel) begin
      gnt_d    = '0;
      ss_act_d = 1'b0;
      ptr_d    = (own_q == IDX_W'(N_REQ - 1)) ? '0 : own_q + 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      gnt_q       <= '0;
      ss_act_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rxd_q   <= '0;
      eng_start_q <= 1'b0;
      eng_txd_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      gnt_q       <= gnt_d;
      ss_act_q    <= ss_act_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rxd_q   <= rsp_rxd_d;
      eng_start_q <= eng_start_d;
      eng_txd_q   <= eng_txd_d;
      drop_q      <= drop_d;
    end
  end

`ifdef SPI_SHARE_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = '0;
`endif

  assign gnt         = gnt_q;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rxd     = rsp_rxd_q;
  assign eng_start   = eng_start_q;
  assign eng_txd     = eng_txd_q;
  assign eng_ss_sel  = own_q;
  assign eng_ss_act  = ss_act_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Bench for spi_share_arbiter: directed scenarios, then four random requesters sharing a modelled engine.
module tb_spi_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SIG_GNT   = 0;
  localparam int SIG_READY = 1;
  localparam int SIG_RSP   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_valid, gnt, req_ready, rsp_valid, timeout_err;
  logic [N*DW-1:0] req_txd;
  logic [DW-1:0]   rsp_rxd, eng_txd, eng_rxd;
  logic            eng_start, eng_busy, eng_done, eng_ss_act;
  logic [1:0]      eng_ss_sel;
  logic [1:0]      dbg_state;

  spi_share_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYC(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .gnt         (gnt),
    .req_valid   (req_valid),
    .req_txd     (req_txd),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rxd     (rsp_rxd),
    .eng_start   (eng_start),
    .eng_txd     (eng_txd),
    .eng_busy    (eng_busy),
    .eng_done    (eng_done),
    .eng_rxd     (eng_rxd),
    .eng_ss_sel  (eng_ss_sel),
    .eng_ss_act  (eng_ss_act),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  int          eng_cnt = 0;
  int          fixed_len = 0;
  bit          fixed_rxd_en = 1'b0;
  logic [DW-1:0] fixed_rxd = '0;

  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_rxd  = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_busy = 1'b0;
          eng_done = 1'b1;
          eng_rxd  = fixed_rxd_en ? fixed_rxd : DW'($urandom);
        end
      end else if (eng_start && !reset) begin
        eng_busy = 1'b1;
        eng_cnt  = (fixed_len > 0) ? fixed_len : $urandom_range(2, 12);
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            have_prev = 1'b0;
  int            m_owner, m_ptr;
  bit            m_pend, m_drop, m_drain;
  logic [N-1:0]    p_req, p_valid;
  logic [N*DW-1:0] p_txd;
  logic            p_busy, p_done;
  logic [DW-1:0]   p_rxd;

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_pend    = 1'b0;
    m_drop    = 1'b0;
    m_drain   = 1'b0;
    have_prev = 1'b0;
    exp_q.delete();
  endtask

  // Predict this cycle's outputs from last cycle's inputs and the ownership model.
  always @(negedge clk) begin
    logic [N-1:0]  e_ready, e_rspv;
    logic          e_start;
    logic [DW-1:0] e_txd, e_rxd, exp_b;
    if (!mon_en) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        e_ready = '0; e_rspv = '0; e_start = 1'b0; e_txd = '0; e_rxd = '0;
        if (m_owner < 0) begin
          if (p_req != '0) begin
            m_owner = rr_first(p_req, m_ptr);
            m_pend = 1'b0; m_drop = 1'b0; m_drain = 1'b0;
          end
        end else if (m_pend) begin
          if (!p_req[m_owner]) m_drop = 1'b1;
          if (p_done) begin
            e_rspv[m_owner] = 1'b1;
            e_rxd   = p_rxd;
            m_pend  = 1'b0;
            m_drain = m_drop;
          end
        end else if (m_drain || !p_req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_drain = 1'b0;
        end else if (p_valid[m_owner] && !p_busy) begin
          e_ready[m_owner] = 1'b1;
          e_start = 1'b1;
          e_txd   = p_txd[m_owner*DW +: DW];
          m_pend  = 1'b1;
          m_drop  = 1'b0;
        end
        check_eq("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check_eq("ss_act", 32'(eng_ss_act), 32'(m_owner >= 0));
        if (m_owner >= 0) check_eq("ss_sel", 32'(eng_ss_sel), 32'(m_owner));
        check_eq("req_ready", 32'(req_ready), 32'(e_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
        check_eq("eng_start", 32'(eng_start), 32'(e_start));
        if (e_start) check_eq("eng_txd", 32'(eng_txd), 32'(e_txd));
        if (e_rspv != '0) check_eq("rsp_rxd", 32'(rsp_rxd), 32'(e_rxd));
        check_eq("timeout_err", 32'(timeout_err), 32'd0);
      end
      if (eng_start) begin
        check_eq("txq_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check_eq("eng_txd_sb", 32'(eng_txd), 32'(exp_b));
        end
      end
      p_req = req; p_valid = req_valid; p_txd = req_txd;
      p_busy = eng_busy; p_done = eng_done; p_rxd = eng_rxd;
      have_prev = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic sig_bit(input int i, input int which);
    case (which)
      SIG_GNT:   return gnt[i];
      SIG_READY: return req_ready[i];
      default:   return rsp_valid[i];
    endcase
  endfunction

  task automatic wait_sig(input int i, input int which, input logic lvl, input int max,
                          input string tag);
    int c = 0;
    while (sig_bit(i, which) !== lvl && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_eq(tag, 32'(sig_bit(i, which)), 32'(lvl));
  endtask

  task automatic send_byte(input int i, input logic [DW-1:0] b, input bit drop, input bit wait_rsp);
    req_txd[i*DW +: DW] = b;
    req_valid[i] = 1'b1;
    wait_sig(i, SIG_READY, 1'b1, 200, "ready_wait");
    exp_q.push_back(b);
    req_valid[i] = 1'b0;
    if (drop) req[i] = 1'b0;
    if (wait_rsp) wait_sig(i, SIG_RSP, 1'b1, 200, "rsp_wait");
  endtask

  task automatic requester(input int i);
    int nb;
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
      req[i] = 1'b1;
      req_txd[i*DW +: DW] = DW'($urandom);
      req_valid[i] = 1'($urandom_range(0, 1));
      wait_sig(i, SIG_GNT, 1'b1, 3000, "gnt_wait");
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        if (k > 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_byte(i, DW'($urandom), (k == nb - 1) && ($urandom_range(0, 3) == 0), 1'b1);
      end
      req[i] = 1'b0;
      wait_sig(i, SIG_GNT, 1'b0, 20, "gnt_release");
    end
  endtask

  // ---------------- main sequence ----------------
  int rsp_seen;

  initial begin
    reset = 1'b1; req = '0; req_valid = '0; req_txd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_eng_start", 32'(eng_start), 32'd0);
    check_eq("rst_ss_act", 32'(eng_ss_act), 32'd0);
    check_eq("rst_eng_txd", 32'(eng_txd), 32'd0);
    check_eq("rst_rsp_rxd", 32'(rsp_rxd), 32'd0);
    check_eq("rst_ss_sel", 32'(eng_ss_sel), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // First grant: round-robin starts at requester 0, so 0110 picks requester 1.
    req = 4'b0110;
    @(posedge clk);
    #1;
    check_eq("t1_gnt", 32'(gnt), 32'h2);
    check_eq("t1_ss_sel", 32'(eng_ss_sel), 32'd1);
    check_eq("t1_ss_act", 32'(eng_ss_act), 32'd1);

    // One byte with a fixed engine response.
    req[3] = 1'b1;
    fixed_len = 10; fixed_rxd = 8'h3C; fixed_rxd_en = 1'b1;
    send_byte(1, 8'hA5, 1'b0, 1'b1);
    check_eq("t2_rsp_rxd", 32'(rsp_rxd), 32'h3C);
    check_eq("t2_gnt_hold", 32'(gnt), 32'h2);
    fixed_rxd_en = 1'b0;

    // Owner drops: one dead cycle, then the next requester in ring order.
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t3_gap_gnt", 32'(gnt), 32'd0);
    check_eq("t3_gap_ss_act", 32'(eng_ss_act), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t3_next_gnt", 32'(gnt), 32'h4);

    // Drop while the byte is in flight: response still delivered, then drain.
    send_byte(2, 8'h5A, 1'b1, 1'b1);
    check_eq("t4_drain_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1;
    check_eq("t4_rel_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t4_next_gnt", 32'(gnt), 32'h8);

    // Reset in the middle of a transfer; the late engine completion must be ignored.
    send_byte(3, 8'hC3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("t5_gnt", 32'(gnt), 32'd0);
    check_eq("t5_ss_act", 32'(eng_ss_act), 32'd0);
    check_eq("t5_eng_txd", 32'(eng_txd), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req = '0;
    req_valid = '0;
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    rsp_seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (rsp_valid != '0) rsp_seen++;
    end
    check_eq("t5_late_rsp", 32'(rsp_seen), 32'd0);
    check_eq("t5_engine_idle", 32'(eng_busy), 32'd0);
    fixed_len = 0;

    // Random contention among all requesters.
    fork
      requester(0);
      requester(1);
      requester(2);
      requester(3);
    join
    repeat (20) @(posedge clk);
    #1;
    check_eq("end_txq_empty", 32'(exp_q.size()), 32'd0);
    check_eq("end_gnt", 32'(gnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
